// File: rtl/hwpe_axi_rr_arbiter_pkg.sv
// Shared types and helpers for the HWPE AXI round-robin packet arbiter.
// Holds the lock state encoding and the modulo pointer increment used by the arbiter.
package hwpe_axi_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Increment with an explicit compare against n-1 so that a non-power-of-two
    // requester count wraps correctly instead of relying on bit truncation.
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
        return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/hwpe_axi_rr_arbiter_if.sv
// Bundle of the requester-side and downstream-side stream signals of the arbiter.
// master = requesters plus downstream sink (the environment), slave = the arbiter itself.
interface hwpe_axi_rr_arbiter_if #(
    parameter int NB_REQ     = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_WIDTH = $clog2(NB_REQ);

    logic [NB_REQ*DATA_WIDTH-1:0] data_in;
    logic [NB_REQ-1:0]            valid_in;
    logic [NB_REQ-1:0]            last_in;
    logic [NB_REQ-1:0]            grant_out;
    logic [DATA_WIDTH-1:0]        data_out;
    logic                         valid_out;
    logic                         last_out;
    logic [ID_WIDTH-1:0]          id_out;
    logic                         grant_in;
    logic                         busy_out;

    modport master (
        output data_in, valid_in, last_in, grant_in,
        input  grant_out, data_out, valid_out, last_out, id_out, busy_out
    );

    modport slave (
        input  data_in, valid_in, last_in, grant_in,
        output grant_out, data_out, valid_out, last_out, id_out, busy_out
    );

endinterface

// File: rtl/hwpe_axi_rr_arbiter_prio_enc.sv
// Rotating priority encoder: picks the first set request starting at ptr and moving upward modulo NB_REQ.
// With no request set, gnt_idx reports ptr itself so the idle id stays on the round-robin pointer.
module hwpe_axi_rr_prio_enc #(
    parameter  int NB_REQ   = 4,
    localparam int ID_WIDTH = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0]   req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] gnt_idx,
    output logic                gnt_valid
);

    // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
    always_comb begin
        int                  cand;
        logic [ID_WIDTH-1:0] idx;
        gnt_idx   = ptr;
        gnt_valid = 1'b0;
        cand      = 0;
        idx       = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NB_REQ) begin
                cand = cand - NB_REQ;
            end
            idx = ID_WIDTH'(cand);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hwpe_axi_rr_arbiter.sv
// Round-robin packet arbiter sharing one valid/grant stream among NB_REQ requesters.
// Payload path is purely combinational; only the lock state, owner and round-robin pointer are registered.
module hwpe_axi_rr_arbiter
    import hwpe_axi_arb_pkg::*;
#(
    parameter  int NB_REQ     = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = $clog2(NB_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    hwpe_axi_rr_arbiter_if.slave  bus
);

    arb_state_t          state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] owner;

    logic [ID_WIDTH-1:0] enc_idx;
    logic                enc_valid;
    logic [ID_WIDTH-1:0] sel;
    logic                sel_valid;
    logic                sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                transfer;

    hwpe_axi_rr_prio_enc #(
        .NB_REQ (NB_REQ)
    ) i_prio_enc (
        .req       (bus.valid_in),
        .ptr       (rr_ptr),
        .gnt_idx   (enc_idx),
        .gnt_valid (enc_valid)
    );

    // While locked, the owner is the only candidate, even if it drops valid between beats.
    always_comb begin
        sel       = (state == LOCKED) ? owner : enc_idx;
        sel_valid = (state == LOCKED) ? bus.valid_in[owner] : enc_valid;
        sel_last  = bus.last_in[sel];
        sel_data  = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (sel == ID_WIDTH'(i)) begin
                sel_data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        transfer = !rst && sel_valid && bus.grant_in;
    end

    always_comb begin
        bus.valid_out = !rst && sel_valid;
        bus.last_out  = !rst && sel_last;
        bus.id_out    = rst ? '0 : sel;
        bus.data_out  = rst ? '0 : sel_data;
        bus.busy_out  = !rst && (state == LOCKED);
        bus.grant_out = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            bus.grant_out[i] = transfer && (sel == ID_WIDTH'(i));
        end
    end

    // The pointer only advances when a packet completes; stalled or partial beats leave it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (transfer) begin
            if (sel_last) begin
                rr_ptr <= ID_WIDTH'(next_rr(32'(sel), 32'(NB_REQ)));
                state  <= IDLE;
            end else begin
                owner  <= sel;
                state  <= LOCKED;
            end
        end
    end

endmodule
